ntt_engine: RTL and testbench
=============================

# ntt_engine

Parametrised forward/inverse number-theoretic transform engine for the Kyber polynomial arithmetic path. It replaces the single-mode inverse transform with one core that runs either the forward NTT (Cooley-Tukey) or the inverse NTT (Gentleman-Sande plus final scaling), selected per run. Coefficients are loaded and read through a word-addressed port instead of flat array ports. All outputs are canonical residues in [0, Q-1].

## Interface
- N, 256, polynomial length (power of two); layers = log2(N)-1
- Q, 3329, modulus
- COEF_W, 12, coefficient width; must satisfy 2^COEF_W > Q
- F, 3303, inverse-NTT scaling factor ((N/2)^-1 mod Q)
- ZETA, 17, primitive root used to build the twiddle table
- clk  in  1  clock
- rst  in  1  reset rst, asynchronous, active-high; clock clk
- start  in  1  run request, sampled only in IDLE
- mode  in  1  0 = forward NTT, 1 = inverse NTT; latched with start
- wr_en  in  1  coefficient write strobe, honoured only in IDLE
- wr_addr  in  log2(N)  write index
- wr_data  in  COEF_W  write value (any value in 0..2^COEF_W-1)
- rd_addr  in  log2(N)  read index
- rd_data  out  COEF_W  registered read data, 1-cycle latency
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at run completion

## Operation
- Storage: N x COEF_W register array. Writes reduce wr_data mod Q before storing (repeated conditional subtract; at COEF_W=12 a single subtract suffices).
- Twiddles: zetas[i] = ZETA^bitrev(i, log2(N)-1) mod Q, i = 0..N/2-1, computed at elaboration.
- Forward (mode=0):
  - len = N/2 down to 2; k starts at 1 and increments once per group; z = zetas[k].
  - t = z*f[j+len] mod Q; f[j+len] = f[j]-t mod Q; f[j] = f[j]+t mod Q.
- Inverse (mode=1):
  - len = 2 up to N/2; k starts at N/2-1 and decrements once per group.
  - t = f[j]; f[j] = t+f[j+len] mod Q; f[j+len] = z*(f[j+len]-t) mod Q.
  - Then every f[i] = f[i]*F mod Q. No -1 remap: the output stays canonical.
- FSM states and transitions:
  - IDLE -> BFLY on start.
  - BFLY: one butterfly per cycle. The j/start/len/k advance is combinational, so there are no idle cycles between groups or layers.
  - After the last butterfly, BFLY -> DONE if forward, or BFLY -> SCALE if inverse.
  - SCALE: one coefficient per cycle, idx 0..N-1, then -> DONE.
  - DONE: done=1 for one cycle, then -> IDLE.
- Arithmetic:
  - Sums and differences are formed in COEF_W+1 bits, corrected with a single conditional ±Q.
  - Products are 2*COEF_W bits, reduced with Barrett or `%`, and result < Q.
- Boundaries:
  - start while busy is ignored.
  - wr_en while busy or in DONE is ignored.
  - rd_addr during busy returns the current partial contents (not meaningful, but defined).
  - start and wr_en in the same IDLE cycle: the write is performed and start is accepted; the run uses the written value.
  - rst mid-run: next state IDLE, busy=0, done=0, storage cleared to 0.

## Timing
- Reset values: rd_data=0, busy=0, done=0, storage all 0, FSM in IDLE.
- Take edge 0 as the edge that accepts start. Forward butterflies then occupy cycles 1..(N/2)*layers.
- N=256 forward: butterflies in cycles 1..896, done=1 in cycle 897, busy=1 in cycles 1..896.
- N=256 inverse: butterflies in 1..896, scaling in 897..1152, done=1 in cycle 1153.
- rd_data is valid one cycle after rd_addr. Results are readable from the done cycle onward.

## Structure
- ntt_pkg holds:
  - mode_t enum (NTT_FWD, NTT_INV)
  - state_t enum (IDLE, BFLY, SCALE, DONE)
  - zeta table generation function
  - Q/F default constants
- Sub-module ntt_butterfly: combinational CT/GS butterfly selected by mode, containing the modular multiply and reduce. The same multiplier is reused in SCALE with operand F.
- ntt_engine holds the FSM, counters, storage and load/read port.

## Test plan
- Load f[0]=1, all other coefficients 0; forward -> even indices = 1, odd indices = 0; done in cycle 897.
- Load the result of the previous scenario; inverse -> f[0]=1, all others 0; done in cycle 1153; busy low from cycle 1153.
- Random canonical vector: forward then inverse -> identical to the original. Each forward output matches the golden Python model bit-exactly.
- wr_data=4095 to all addresses, then read back before starting -> 766 at every address; wr_en pulsed during busy -> no change.
- start pulsed again at cycle 100 of a run -> ignored, single done at 897. Assert rst at cycle 400 of a run -> busy=0 next cycle, no done, rd_data(any address)=0.
- All-zero input, inverse -> all outputs 0; done high for exactly one cycle; next start accepted in the following IDLE cycle.

Source files
------------

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared types, default constants and the twiddle-table helper
// for the forward/inverse number-theoretic transform engine.
package ntt_pkg;

   typedef enum logic {
      NTT_FWD = 1'b0,
      NTT_INV = 1'b1
   } mode_t;

   typedef enum logic [1:0] {
      IDLE,
      BFLY,
      SCALE,
      DONE
   } state_t;

   localparam int Q_DEF    = 3329;
   localparam int F_DEF    = 3303;
   localparam int ZETA_DEF = 17;

   // Reverse the low 'bits' bits of v.
   function automatic int unsigned bitrev(input int unsigned v, input int unsigned bits);
      int unsigned r;
      r = 0;
      for (int unsigned b = 0; b < bits; b++)
         r = (r << 1) | ((v >> b) & 32'd1);
      return r;
   endfunction

   // Twiddle entry i: zeta^bitrev(i, bits) mod q, evaluated at elaboration.
   function automatic int unsigned zeta_entry(input int unsigned i, input int unsigned bits,
                                              input int unsigned q, input int unsigned zeta);
      longint unsigned r;
      int unsigned     e;
      r = 1;
      e = bitrev(i, bits);
      for (int unsigned n = 0; n < e; n++)
         r = (r * zeta) % q;
      return 32'(r);
   endfunction

endpackage

// File: rtl/ntt_engine_if.sv
// ntt_engine_if: run control, coefficient load port and read port of the
// NTT engine. The engine sits on the slave side.
interface ntt_engine_if #(
   parameter int N      = 256,
   parameter int COEF_W = 12
);
   localparam int LOGN = $clog2(N);

   logic              start;
   logic              mode;
   logic              wr_en;
   logic [LOGN-1:0]   wr_addr;
   logic [COEF_W-1:0] wr_data;
   logic [LOGN-1:0]   rd_addr;
   logic [COEF_W-1:0] rd_data;
   logic              busy;
   logic              done;

   modport master (
      output start, mode, wr_en, wr_addr, wr_data, rd_addr,
      input  rd_data, busy, done
   );

   modport slave (
      input  start, mode, wr_en, wr_addr, wr_data, rd_addr,
      output rd_data, busy, done
   );
endinterface

// File: rtl/ntt_butterfly.sv
// ntt_butterfly: combinational Cooley-Tukey / Gentleman-Sande butterfly.
// The single modular multiplier also serves the final scaling pass, where
// the caller feeds the scale factor on z and sets 'scale'.
module ntt_butterfly
   import ntt_pkg::*;
#(
   parameter int Q      = Q_DEF,
   parameter int COEF_W = 12
) (
   input  mode_t             mode,
   input  logic              scale,
   input  logic [COEF_W-1:0] a,
   input  logic [COEF_W-1:0] b,
   input  logic [COEF_W-1:0] z,
   output logic [COEF_W-1:0] x,
   output logic [COEF_W-1:0] y
);
   localparam int W1 = COEF_W + 1;
   localparam int PW = 2 * COEF_W;
   localparam logic [COEF_W:0] QE = W1'(Q);

   logic [COEF_W-1:0] diff_ba;
   logic [COEF_W-1:0] mul_in;
   logic [COEF_W-1:0] prod;
   logic [PW-1:0]     prod_full;

   // Canonical inputs: one conditional subtract brings the sum back under Q.
   function automatic logic [COEF_W-1:0] add_mod(input logic [COEF_W-1:0] p,
                                                 input logic [COEF_W-1:0] m);
      logic [COEF_W:0] s;
      s = {1'b0, p} + {1'b0, m};
      if (s >= QE) s = s - QE;
      return s[COEF_W-1:0];
   endfunction

   // A negative difference wraps in COEF_W+1 bits; adding Q lands it in range.
   function automatic logic [COEF_W-1:0] sub_mod(input logic [COEF_W-1:0] p,
                                                 input logic [COEF_W-1:0] m);
      logic [COEF_W:0] s;
      s = {1'b0, p} - {1'b0, m};
      if (p < m) s = s + QE;
      return s[COEF_W-1:0];
   endfunction

   // Pick the multiplier operand: scaled coefficient, CT upper input, or GS difference.
   always_comb begin
      diff_ba = sub_mod(b, a);
      if (scale)
         mul_in = a;
      else if (mode == NTT_FWD)
         mul_in = b;
      else
         mul_in = diff_ba;
   end

   assign prod_full = {{COEF_W{1'b0}}, mul_in} * {{COEF_W{1'b0}}, z};
   assign prod      = COEF_W'(prod_full % PW'(Q));

   // Combine the product into the two butterfly outputs.
   always_comb begin
      if (scale) begin
         x = prod;
         y = prod;
      end else if (mode == NTT_FWD) begin
         x = add_mod(a, prod);
         y = sub_mod(a, prod);
      end else begin
         x = add_mod(a, b);
         y = prod;
      end
   end

endmodule

// File: rtl/ntt_engine.sv
// ntt_engine: forward/inverse NTT over a register-array polynomial.
// One butterfly per cycle, index/group/layer advance with no bubbles,
// followed (inverse only) by a one-coefficient-per-cycle scaling pass.
module ntt_engine
   import ntt_pkg::*;
#(
   parameter int N      = 256,
   parameter int Q      = Q_DEF,
   parameter int COEF_W = 12,
   parameter int F      = F_DEF,
   parameter int ZETA   = ZETA_DEF
) (
   input  logic          clk,
   input  logic          rst,
   ntt_engine_if.slave   bus
);
   localparam int LOGN      = $clog2(N);
   localparam int KW        = LOGN - 1;
   localparam int RED_STEPS = ((1 << COEF_W) - 1) / Q;
   localparam logic [COEF_W-1:0] QC = COEF_W'(Q);

   state_t            state;
   mode_t             run_mode;
   logic [LOGN-1:0]   j, grp, len;
   logic [KW-1:0]     k;
   logic              busy_q, done_q;
   logic [COEF_W-1:0] rd_q;
   logic [COEF_W-1:0] mem [N];

   logic [LOGN:0]     j_inc, grp_end, grp_nxt;
   logic [LOGN-1:0]   j_hi;
   logic [KW-1:0]     k_step;
   logic              group_last, last_layer;
   logic [COEF_W-1:0] wr_red;
   logic [COEF_W-1:0] bf_z, bf_x, bf_y;
   logic [COEF_W-1:0] zetas [N/2];

   for (genvar gi = 0; gi < N/2; gi++) begin : g_zeta
      localparam logic [COEF_W-1:0] ZV = COEF_W'(zeta_entry(gi, LOGN-1, Q, ZETA));
      assign zetas[gi] = ZV;
   end

   // Butterfly walk: j runs inside a group [grp, grp+len), groups step by 2*len.
   assign j_inc      = {1'b0, j} + 1'b1;
   assign grp_end    = {1'b0, grp} + {1'b0, len};
   assign grp_nxt    = {1'b0, grp} + {len, 1'b0};
   assign group_last = (j_inc == grp_end);
   assign last_layer = (run_mode == NTT_FWD) ? (len == LOGN'(2)) : (len == LOGN'(N/2));
   assign j_hi       = j + len;
   assign k_step     = (run_mode == NTT_FWD) ? k + 1'b1 : k - 1'b1;
   assign bf_z       = (state == SCALE) ? COEF_W'(F) : zetas[k];

   // Fold an arbitrary write value into [0, Q-1].
   always_comb begin
      wr_red = bus.wr_data;
      for (int i = 0; i < RED_STEPS; i++)
         if (wr_red >= QC) wr_red = wr_red - QC;
   end

   ntt_butterfly #(.Q(Q), .COEF_W(COEF_W)) u_bfly (
      .mode  (run_mode),
      .scale (state == SCALE),
      .a     (mem[j]),
      .b     (mem[j_hi]),
      .z     (bf_z),
      .x     (bf_x),
      .y     (bf_y)
   );

   // Run FSM with counters and registered busy/done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         run_mode <= NTT_FWD;
         j        <= '0;
         grp      <= '0;
         len      <= '0;
         k        <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               state    <= BFLY;
               busy_q   <= 1'b1;
               run_mode <= mode_t'(bus.mode);
               j        <= '0;
               grp      <= '0;
               len      <= bus.mode ? LOGN'(2) : LOGN'(N/2);
               k        <= bus.mode ? KW'(N/2-1) : KW'(1);
            end
            BFLY: begin
               if (!group_last) begin
                  j <= j_inc[LOGN-1:0];
               end else if (!grp_nxt[LOGN]) begin
                  grp <= grp_nxt[LOGN-1:0];
                  j   <= grp_nxt[LOGN-1:0];
                  k   <= k_step;
               end else if (!last_layer) begin
                  grp <= '0;
                  j   <= '0;
                  k   <= k_step;
                  len <= (run_mode == NTT_FWD) ? len >> 1 : len << 1;
               end else if (run_mode == NTT_INV) begin
                  state <= SCALE;
                  j     <= '0;
               end else begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            SCALE: begin
               if (j == LOGN'(N-1)) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  j <= j + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Coefficient storage: host writes in IDLE, butterfly/scale results while running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) mem[i] <= '0;
      end else begin
         case (state)
            IDLE: if (bus.wr_en) mem[bus.wr_addr] <= wr_red;
            BFLY: begin
               mem[j]    <= bf_x;
               mem[j_hi] <= bf_y;
            end
            SCALE:   mem[j] <= bf_x;
            default: ;
         endcase
      end
   end

   // Registered read port, one cycle behind rd_addr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_q <= '0;
      else     rd_q <= mem[bus.rd_addr];
   end

   assign bus.rd_data = rd_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_ntt_engine.sv
// tb_ntt_engine: directed checks of the NTT engine - reset state, write
// reduction, delta transforms, round trip against a reference model,
// ignored start/write while running, mid-run reset and back-to-back runs.
module tb_ntt_engine;
   localparam int N = 256;
   localparam int Q = 3329;
   localparam int W = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ntt_engine_if #(.N(N), .COEF_W(W)) bus ();

   ntt_engine #(.N(N), .Q(Q), .COEF_W(W), .F(3303), .ZETA(17)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int zt    [N/2];
   int orig  [N];
   int ref_v [N];
   int img   [N];
   int rb    [N];

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load();
      for (int a = 0; a < N; a++) begin
         @(negedge clk);
         bus.wr_en   = 1'b1;
         bus.wr_addr = 8'(a);
         bus.wr_data = 12'(img[a]);
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic dump();
      @(negedge clk);
      bus.rd_addr = '0;
      for (int a = 1; a <= N; a++) begin
         @(negedge clk);
         rb[a-1] = int'(bus.rd_data);
         if (a < N) bus.rd_addr = 8'(a);
      end
   endtask

   // Reference forward transform on ref_v.
   function automatic void fwd_model();
      int k;
      k = 1;
      for (int len = N/2; len >= 2; len = len / 2)
         for (int s = 0; s < N; s += 2*len) begin
            int z;
            z = zt[k];
            k++;
            for (int j = s; j < s + len; j++) begin
               int t;
               t = (z * ref_v[j+len]) % Q;
               ref_v[j+len] = (ref_v[j] - t + Q) % Q;
               ref_v[j]     = (ref_v[j] + t) % Q;
            end
         end
   endfunction

   // Start a run at edge 0 and watch busy/done up to two cycles past the expected done.
   task automatic run_ntt(input string tag, input logic m, input int exp_done,
                          input bit wr_with_start, input bit poke, input bit restart);
      int done_at, n_done;
      done_at = -1;
      n_done  = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = m;
      if (wr_with_start) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = '0;
         bus.wr_data = 12'd1;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      for (int c = 1; c <= exp_done + 2; c++) begin
         @(negedge clk);
         if (bus.done) begin
            n_done++;
            if (done_at < 0) done_at = c;
         end
         bus.start = 1'b0;
         bus.wr_en = 1'b0;
         if (c == 1)            chk({tag, "_busy_first"}, int'(bus.busy), 1);
         if (c == exp_done - 1) chk({tag, "_busy_last"}, int'(bus.busy), 1);
         if (c == exp_done)     chk({tag, "_busy_at_done"}, int'(bus.busy), 0);
         if (poke && (c == 100 || c == exp_done)) begin
            bus.start   = (c == 100);
            bus.wr_en   = 1'b1;
            bus.wr_addr = (c == 100) ? 8'd5 : 8'd7;
            bus.wr_data = (c == 100) ? 12'd99 : 12'd55;
         end
         if (restart && c == exp_done + 1) begin
            bus.start = 1'b1;
            bus.mode  = 1'b0;
         end
         if (restart && c == exp_done + 2) chk({tag, "_restart_busy"}, int'(bus.busy), 1);
      end
      chk({tag, "_done_cycle"}, done_at, exp_done);
      chk({tag, "_done_pulses"}, n_done, 1);
   endtask

   initial begin
      int cnt;
      bus.start   = 1'b0;
      bus.mode    = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.rd_addr = '0;

      for (int i = 0; i < N/2; i++) begin
         int e, r;
         e = 0;
         for (int b = 0; b < 7; b++) e = (e << 1) | ((i >> b) & 1);
         r = 1;
         repeat (e) r = (r * 17) % Q;
         zt[i] = r;
      end

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_rd_data", int'(bus.rd_data), 0);
      rst = 1'b0;
      dump();
      for (int a = 0; a < N; a += 85) chk($sformatf("rst_mem[%0d]", a), rb[a], 0);

      // Write reduction: 4095 mod 3329 = 766
      for (int a = 0; a < N; a++) img[a] = 4095;
      load();
      dump();
      for (int a = 0; a < N; a++) chk($sformatf("wr_red[%0d]", a), rb[a], 766);

      // Delta forward; f[0]=1 written in the start cycle; start/write pokes ignored
      for (int a = 0; a < N; a++) img[a] = 0;
      load();
      run_ntt("fwd_delta", 1'b0, 897, 1'b1, 1'b1, 1'b0);
      dump();
      for (int a = 0; a < N; a++) chk($sformatf("fwd_delta[%0d]", a), rb[a], (a % 2 == 0) ? 1 : 0);

      // Inverse of that result gives the delta back
      run_ntt("inv_delta", 1'b1, 1153, 1'b0, 1'b0, 1'b0);
      dump();
      for (int a = 0; a < N; a++) chk($sformatf("inv_delta[%0d]", a), rb[a], (a == 0) ? 1 : 0);

      // Random vector: forward against model, then inverse back to the original
      for (int a = 0; a < N; a++) begin
         orig[a]  = int'($urandom_range(0, Q-1));
         img[a]   = orig[a];
         ref_v[a] = orig[a];
      end
      fwd_model();
      load();
      run_ntt("fwd_rand", 1'b0, 897, 1'b0, 1'b0, 1'b0);
      dump();
      for (int a = 0; a < N; a++) chk($sformatf("fwd_rand[%0d]", a), rb[a], ref_v[a]);
      run_ntt("inv_rand", 1'b1, 1153, 0, 0, 0);
      dump();
      for (int a = 0; a < N; a++) chk($sformatf("round_trip[%0d]", a), rb[a], orig[a]);

      // All-zero inverse, then a new start in the very next IDLE cycle
      for (int a = 0; a < N; a++) img[a] = 0;
      load();
      run_ntt("inv_zero", 1'b1, 1153, 1'b0, 1'b0, 1'b1);
      cnt = 0;
      while (!bus.done && cnt < 1000) begin
         @(negedge clk);
         cnt++;
      end
      chk("restart_done_seen", int'(bus.done), 1);
      dump();
      for (int a = 0; a < N; a++) chk($sformatf("zero[%0d]", a), rb[a], 0);

      // Reset in cycle 400 of a forward run
      for (int a = 0; a < N; a++) img[a] = orig[a];
      load();
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (400) @(negedge clk);
      chk("midrst_busy_before", int'(bus.busy), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_done", int'(bus.done), 0);
      chk("midrst_rd_data", int'(bus.rd_data), 0);
      rst = 1'b0;
      cnt = 0;
      repeat (1000) begin
         @(negedge clk);
         if (bus.done) cnt++;
      end
      chk("midrst_no_done", cnt, 0);
      dump();
      for (int a = 0; a < N; a++) chk($sformatf("midrst_mem[%0d]", a), rb[a], 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
